// File: rtl/bank_arbiter.sv
// Two-port round-robin arbiter in front of a shared banked memory with combinational read data.
// Latency: grant is combinational in the request cycle; read data and rvalid are registered, so they appear one cycle after the grant.
// Backpressure: a requester holds req/wen/addr/wdata until it sees gnt. The loser of a tie is granted on the next cycle.
// Optional macro ARB_STATS_EN adds saturating 16-bit per-port grant counters (p0_gcnt/p1_gcnt).
module bank_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_wen,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic          p1_wen,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_rvalid,
    output logic          p1_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   p0_gcnt,
    output logic [15:0]   p1_gcnt
`endif
);

    // last_q names the port granted most recently (1 after reset, so port 0 wins the first tie).
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          p0_rvalid_q, p0_rvalid_d;
    logic          p1_rvalid_q, p1_rvalid_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;
    logic          g0, g1;

    // Arbitration, memory-side mux and next-state. The bank bits travel with the address,
    // so the memory decodes them and nothing here needs to.
    always_comb begin
        g0          = ~rst & p0_req & (~p1_req | last_q);
        g1          = ~rst & p1_req & (~p0_req | ~last_q);
        mem_wen     = 1'b0;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        last_d      = last_q;
        p0_rvalid_d = g0 & ~p0_wen;
        p1_rvalid_d = g1 & ~p1_wen;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        if (g0) begin
            mem_wen   = p0_wen;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            last_d    = 1'b0;
            if (!p0_wen) p0_rdata_d = mem_rdata;
        end else if (g1) begin
            mem_wen   = p1_wen;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            last_d    = 1'b1;
            if (!p1_wen) p1_rdata_d = mem_rdata;
        end
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
    end

    // State registers; memory-side address/data hold the last granted values when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    // Reset must also hide a read response already in flight, so outputs are masked while rst is high.
    assign p0_gnt    = g0;
    assign p1_gnt    = g1;
    assign p0_rvalid = p0_rvalid_q & ~rst;
    assign p1_rvalid = p1_rvalid_q & ~rst;
    assign p0_rdata  = rst ? '0 : p0_rdata_q;
    assign p1_rdata  = rst ? '0 : p1_rdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] p0_gcnt_q, p1_gcnt_q;

    // Per-port grant counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_gcnt_q <= '0;
            p1_gcnt_q <= '0;
        end else begin
            if (g0 && p0_gcnt_q != 16'hFFFF) p0_gcnt_q <= p0_gcnt_q + 16'd1;
            if (g1 && p1_gcnt_q != 16'hFFFF) p1_gcnt_q <= p1_gcnt_q + 16'd1;
        end
    end

    assign p0_gcnt = p0_gcnt_q;
    assign p1_gcnt = p1_gcnt_q;
`endif

endmodule
